port_arbiter: RTL

Clocked round-robin arbiter that shares one router output channel between `N_IN` competing input ports. It uses the same two-phase (toggle) req/ack handshake as the NoC links on both sides. It sits between the input buffers of a router and one output link (local, N, S, E or W). It also latches the winning packet and holds it stable until the downstream hop acknowledges.

---
 rtl/port_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/port_arbiter.sv
// port_arbiter: round-robin N_IN:1 toggle-handshake arbiter (req_i/data_i/ack_i per input, req_o/data_o/ack_o to the link, grant_o/busy_o/pkt_cnt_o/err_o status)
`timescale 1ns/1ps
module port_arbiter #(
  parameter int N_IN = 4,
  parameter int PAYLOAD = 32,
  parameter int X_BITS = 1,
  parameter int Y_BITS = 1,
  parameter int PACKET_W = X_BITS + Y_BITS + 2 + PAYLOAD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          req_i,
  input  logic [N_IN*PACKET_W-1:0] data_i,
  output logic [N_IN-1:0]          ack_i,
  output logic                     req_o,
  output logic [PACKET_W-1:0]      data_o,
  input  logic                     ack_o,
  output logic [N_IN-1:0]          grant_o,
  output logic                     busy_o,
  output logic [15:0]              pkt_cnt_o,
  output logic                     err_o
);
  localparam int IW = $clog2(N_IN);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] ptr, win, sel;
  logic [N_IN-1:0] pend;
  logic found, take, done;
  assign pend = req_i ^ ack_i;
  always_comb begin
    sel = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_IN; k++)
      if (!found && pend[(int'(ptr) + k) % N_IN]) begin
        found = 1'b1;
        sel = IW'((int'(ptr) + k) % N_IN);
      end
  end
  // an unmatched ack_o in IDLE keeps the link outstanding, so no grant until it realigns
  always_comb begin
    take = 1'b0;
    done = 1'b0;
    take = state == IDLE && found && ack_o == req_o;
    done = state == WAIT && ack_o == req_o;
    state_nxt = take ? WAIT : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IW'(N_IN - 1);
      win <= '0;
      req_o <= 1'b0;
      ack_i <= '0;
      data_o <= '0;
      grant_o <= '0;
      busy_o <= 1'b0;
      pkt_cnt_o <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ack_o != req_o) err_o <= 1'b1;
      if (take) begin
        win <= sel;
        data_o <= data_i[int'(sel)*PACKET_W +: PACKET_W];
        req_o <= ~req_o;
        grant_o <= N_IN'(1) << sel;
        busy_o <= 1'b1;
      end
      if (done) begin
        ack_i[win] <= ~ack_i[win];
        ptr <= win;
        grant_o <= '0;
        busy_o <= 1'b0;
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      end
    end
  end
endmodule
